// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the conditional-branch control-step sequencer.
// State encoding, opcode field location and the datapath strobe bundle live here.
package branch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd1,
    ST_WAIT = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;
  localparam int         OPC_MSB       = 31;
  localparam int         OPC_LSB       = 27;

  typedef struct packed {
    logic gra;
    logic r_out;
    logic con_in;
    logic pc_out;
    logic y_in;
    logic c_out;
    logic alu_add;
    logic z_in;
    logic zlo_out;
    logic pc_in;
  } strobe_t;

  // T6 only moves Z into the PC when the condition held.
  function automatic strobe_t decode_strobes(input state_t st, input logic tkn);
    strobe_t s;
    s = '0;
    case (st)
      ST_T3: begin
        s.gra    = 1'b1;
        s.r_out  = 1'b1;
        s.con_in = 1'b1;
      end
      ST_T4: begin
        s.pc_out = 1'b1;
        s.y_in   = 1'b1;
      end
      ST_T5: begin
        s.c_out   = 1'b1;
        s.alu_add = 1'b1;
        s.z_in    = 1'b1;
      end
      ST_T6: begin
        s.zlo_out = tkn;
        s.pc_in   = tkn;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Control handshake plus datapath strobes between the main controller and the branch sequencer.
// slave = sequencer side, master = controller/datapath side.
interface branch_sequencer_if;

  logic        start;
  logic [31:0] ir;
  logic        con_q;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        taken;
  logic        gra;
  logic        r_out;
  logic        con_in;
  logic        pc_out;
  logic        y_in;
  logic        c_out;
  logic        alu_add;
  logic        z_in;
  logic        zlo_out;
  logic        pc_in;

  modport slave (
    input  start, ir, con_q,
    output busy, done, illegal, taken,
    output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in
  );

  modport master (
    output start, ir, con_q,
    input  busy, done, illegal, taken,
    input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in
  );

endinterface

// File: rtl/branch_sequencer_stats.sv
// branch_stats: saturating taken / not-taken counters for the branch sequencer.
// Synchronous clear wins over a same-cycle increment.
module branch_stats (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stat_clr,
  input  logic        inc_taken,
  input  logic        inc_not_taken,
  output logic [15:0] taken_cnt,
  output logic [15:0] not_taken_cnt
);

  logic [15:0] taken_cnt_d, taken_cnt_q;
  logic [15:0] not_taken_cnt_d, not_taken_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (stat_clr) begin
      taken_cnt_d     = '0;
      not_taken_cnt_d = '0;
    end else begin
      if (inc_taken)     taken_cnt_d     = sat_inc(taken_cnt_q);
      if (inc_not_taken) not_taken_cnt_d = sat_inc(not_taken_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

endmodule

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: registered one-hot strobes for T3..T6 and the PC load.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters with stat_clr.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF,
  parameter int         WAIT_CON  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  branch_sequencer_if.slave  bus
`ifdef BRANCH_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        taken_cnt,
  output logic [15:0]        not_taken_cnt
`endif
);

  // WAIT is entered holding the last count value so it lasts exactly WAIT_CON cycles.
  localparam logic [1:0] WAIT_LAST = (WAIT_CON > 0) ? 2'(WAIT_CON - 1) : 2'd0;

  state_t     state_d, state_q;
  logic [1:0] cnt_d, cnt_q;
  logic       taken_d, taken_q;
  logic       illegal_d, illegal_q;
  logic       done_d, done_q;
  logic       busy_d, busy_q;
  strobe_t    strobe_d, strobe_q;

  logic [4:0]  opc;
  logic [26:0] unused_ir;

  assign opc       = bus.ir[OPC_MSB:OPC_LSB];
  assign unused_ir = bus.ir[OPC_LSB-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    taken_d   = taken_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (opc == BR_OPCODE) begin
            state_d = ST_T3;
            taken_d = 1'b0;
          end else begin
            state_d   = ST_FIN;
            illegal_d = 1'b1;
          end
        end
      end
      ST_T3: begin
        if (WAIT_CON > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LAST;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_T4;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_T4: state_d = ST_T5;
      // Condition flip-flop result is captured on the edge that enters T6.
      ST_T5: begin
        state_d = ST_T6;
        taken_d = bus.con_q;
      end
      ST_T6:   state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    strobe_d = decode_strobes(state_d, taken_d);
    done_d   = (state_d == ST_FIN);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.taken   = taken_q;
  assign bus.gra     = strobe_q.gra;
  assign bus.r_out   = strobe_q.r_out;
  assign bus.con_in  = strobe_q.con_in;
  assign bus.pc_out  = strobe_q.pc_out;
  assign bus.y_in    = strobe_q.y_in;
  assign bus.c_out   = strobe_q.c_out;
  assign bus.alu_add = strobe_q.alu_add;
  assign bus.z_in    = strobe_q.z_in;
  assign bus.zlo_out = strobe_q.zlo_out;
  assign bus.pc_in   = strobe_q.pc_in;

`ifdef BRANCH_STATS_EN
  logic inc_taken, inc_not_taken;

  assign inc_taken     = (state_q == ST_T6) &&  taken_q;
  assign inc_not_taken = (state_q == ST_T6) && !taken_q;

  branch_stats u_stats (
    .clk           (clk),
    .reset_n       (reset_n),
    .stat_clr      (stat_clr),
    .inc_taken     (inc_taken),
    .inc_not_taken (inc_not_taken),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );
`endif

  // Bus contention and a PC load without its source would corrupt the datapath.
  a_one_bus_driver : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({strobe_q.r_out, strobe_q.pc_out, strobe_q.c_out, strobe_q.zlo_out}));

  a_pc_in_needs_zlo : assert property (@(posedge clk) disable iff (!reset_n)
    strobe_q.pc_in |-> strobe_q.zlo_out);

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer (WAIT_CON=1); covers stats when BRANCH_STATS_EN is defined.
module tb_branch_sequencer;

  localparam int         WAIT_CON = 1;
  localparam logic [4:0] BR       = 5'b10010;

  localparam logic [9:0] S_NONE = 10'b0000000000;
  localparam logic [9:0] S_T3   = 10'b1110000000;
  localparam logic [9:0] S_T4   = 10'b0001100000;
  localparam logic [9:0] S_T5   = 10'b0000011100;
  localparam logic [9:0] S_T6   = 10'b0000000011;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  branch_sequencer_if bif ();

`ifdef BRANCH_STATS_EN
  logic        stat_clr;
  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;
`endif

  branch_sequencer #(.BR_OPCODE(BR), .WAIT_CON(WAIT_CON)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bif)
`ifdef BRANCH_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, done, illegal, taken, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in}
  logic [13:0] obs;
  assign obs = {bif.busy, bif.done, bif.illegal, bif.taken,
                bif.gra, bif.r_out, bif.con_in, bif.pc_out, bif.y_in,
                bif.c_out, bif.alu_add, bif.z_in, bif.zlo_out, bif.pc_in};

  function automatic logic [13:0] ex(input logic b, input logic d, input logic i,
                                     input logic t, input logic [9:0] s);
    return {b, d, i, t, s};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full legal branch with per-cycle output checks; ir is scrambled after acceptance
  // and con_q is inverted after T6 entry, neither of which may affect the result.
  task automatic run_legal(input string tag, input logic c, input logic inject_start,
                           input logic clr_in_t6);
    bif.ir    = {BR, 27'h0};
    bif.con_q = c;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    bif.ir    = 32'hFFFF_FFFF;
    check_eq({tag, "_t3"}, 32'(obs), 32'(ex(1, 0, 0, 0, S_T3)));
    for (int w = 0; w < WAIT_CON; w++) begin
      tick();
      check_eq({tag, "_wait"}, 32'(obs), 32'(ex(1, 0, 0, 0, S_NONE)));
    end
    tick();
    check_eq({tag, "_t4"}, 32'(obs), 32'(ex(1, 0, 0, 0, S_T4)));
    if (inject_start) begin
      bif.start = 1'b1;
      bif.ir    = {BR, 27'h0};
    end
    tick();
    bif.start = 1'b0;
    check_eq({tag, "_t5"}, 32'(obs), 32'(ex(1, 0, 0, 0, S_T5)));
    tick();
    check_eq({tag, "_t6"}, 32'(obs), 32'(ex(1, 0, 0, c, c ? S_T6 : S_NONE)));
    bif.con_q = ~c;
`ifdef BRANCH_STATS_EN
    if (clr_in_t6) stat_clr = 1'b1;
`endif
    tick();
`ifdef BRANCH_STATS_EN
    stat_clr = 1'b0;
`endif
    check_eq({tag, "_fin"}, 32'(obs), 32'(ex(1, 1, 0, c, S_NONE)));
    tick();
    check_eq({tag, "_idle"}, 32'(obs), 32'(ex(0, 0, 0, c, S_NONE)));
    if (inject_start || clr_in_t6) begin
      tick();
      check_eq({tag, "_still_idle"}, 32'(obs), 32'(ex(0, 0, 0, c, S_NONE)));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    bif.start = 1'b0;
    bif.ir    = '0;
    bif.con_q = 1'b0;
`ifdef BRANCH_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", 32'(obs), 32'h0);
`ifdef BRANCH_STATS_EN
    check_eq("reset_taken_cnt", 32'(taken_cnt), 32'h0);
    check_eq("reset_not_taken_cnt", 32'(not_taken_cnt), 32'h0);
`endif
    #3 reset_n = 1'b1;
    tick();
    check_eq("idle_after_reset", 32'(obs), 32'h0);

    run_legal("taken", 1'b1, 1'b0, 1'b0);

    // Illegal opcode: done+illegal one cycle after start, taken left at 1.
    bif.ir    = {5'b00011, 27'h12345};
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    check_eq("illegal_fin", 32'(obs), 32'(ex(1, 1, 1, 1, S_NONE)));
    tick();
    check_eq("illegal_idle", 32'(obs), 32'(ex(0, 0, 0, 1, S_NONE)));

    run_legal("not_taken", 1'b0, 1'b0, 1'b0);
    run_legal("ignored_start", 1'b1, 1'b1, 1'b0);

    // Reset asserted during T5 aborts before any PC load.
    bif.ir    = {BR, 27'h0};
    bif.con_q = 1'b1;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (WAIT_CON + 2) tick();
    check_eq("pre_abort_t5", 32'(obs), 32'(ex(1, 0, 0, 0, S_T5)));
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_reset", 32'(obs), 32'h0);
    tick();
    check_eq("held_reset", 32'(obs), 32'h0);
    reset_n = 1'b1;
    tick();
    check_eq("idle_after_abort", 32'(obs), 32'h0);
    run_legal("after_abort", 1'b1, 1'b0, 1'b0);

`ifdef BRANCH_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_eq("clr_taken_cnt", 32'(taken_cnt), 32'h0);
    check_eq("clr_not_taken_cnt", 32'(not_taken_cnt), 32'h0);
    run_legal("st1", 1'b1, 1'b0, 1'b0);
    run_legal("st2", 1'b0, 1'b0, 1'b0);
    run_legal("st3", 1'b1, 1'b0, 1'b0);
    run_legal("st4", 1'b0, 1'b0, 1'b0);
    run_legal("st5", 1'b1, 1'b0, 1'b0);
    check_eq("taken_cnt_3", 32'(taken_cnt), 32'd3);
    check_eq("not_taken_cnt_2", 32'(not_taken_cnt), 32'd2);
    run_legal("clr_t6", 1'b1, 1'b0, 1'b1);
    check_eq("clr_t6_taken_cnt", 32'(taken_cnt), 32'h0);
    check_eq("clr_t6_not_taken_cnt", 32'(not_taken_cnt), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
